// File: rtl/upordown_counter.sv
// Synchronous up/down counter, wraps modulo 2^WIDTH in both directions.
// Optional terminal-count output Tc when UPORDOWN_TC_EN is defined.
module upordown_counter #(
  parameter int          WIDTH       = 4,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             UpOrDown,
  output logic [WIDTH-1:0] Count
`ifdef UPORDOWN_TC_EN
  ,
  output logic             Tc
`endif
);

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

  // Declaration initializer gives a defined power-up value even without reset.
  logic [WIDTH-1:0] Count_q = RST_V;

  always_ff @(posedge Clk) begin
    if (reset)         Count_q <= RST_V;
    else if (UpOrDown) Count_q <= Count_q + 1'b1;
    else               Count_q <= Count_q - 1'b1;
  end

  assign Count = Count_q;

`ifdef UPORDOWN_TC_EN
  // High in the cycle before a wrap in the selected direction.
  assign Tc = !reset && (UpOrDown ? (&Count_q) : ~(|Count_q));
`endif

endmodule

// File: tb/tb_upordown_counter.sv
// Randomized/directed bench for upordown_counter: a 4-bit default instance
// and a 3-bit instance with non-zero reset value, both checked against a model.
module tb_upordown_counter;
  localparam int W0 = 4, RV0 = 0;
  localparam int W1 = 3, RV1 = 5;

  logic          Clk = 1'b0;
  logic          reset = 1'b0;
  logic          UpOrDown = 1'b0;
  logic [W0-1:0] cnt0;
  logic [W1-1:0] cnt1;
`ifdef UPORDOWN_TC_EN
  logic          tc0, tc1;
`endif

  int total = 0, passed = 0, failed = 0;
  int m0 = RV0, m1 = RV1;  // reference model counts

  upordown_counter #(.WIDTH(W0), .RESET_VALUE(RV0)) dut0 (
    .Clk(Clk), .reset(reset), .UpOrDown(UpOrDown), .Count(cnt0)
`ifdef UPORDOWN_TC_EN
    , .Tc(tc0)
`endif
  );

  upordown_counter #(.WIDTH(W1), .RESET_VALUE(RV1)) dut1 (
    .Clk(Clk), .reset(reset), .UpOrDown(UpOrDown), .Count(cnt1)
`ifdef UPORDOWN_TC_EN
    , .Tc(tc1)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int next(input int c, input int w, input int rv,
                              input logic r, input logic u);
    int m = 1 << w;
    if (r) return rv;
    return u ? (c + 1) % m : (c + m - 1) % m;
  endfunction

  // Drive inputs, check Tc before the edge, then check Count after it.
  task automatic step(input logic r, input logic u, input string tag);
    reset = r;
    UpOrDown = u;
    #1;
`ifdef UPORDOWN_TC_EN
    chk({tag, "_tc0"}, {31'd0, tc0}, (!r && (u ? m0 == (1 << W0) - 1 : m0 == 0)) ? 1 : 0);
    chk({tag, "_tc1"}, {31'd0, tc1}, (!r && (u ? m1 == (1 << W1) - 1 : m1 == 0)) ? 1 : 0);
`endif
    @(posedge Clk);
    m0 = next(m0, W0, RV0, r, u);
    m1 = next(m1, W1, RV1, r, u);
    #1;
    chk({tag, "_cnt0"}, {{(32-W0){1'b0}}, cnt0}, m0);
    chk({tag, "_cnt1"}, {{(32-W1){1'b0}}, cnt1}, m1);
  endtask

  initial begin
    #1;
    chk("powerup_cnt0", {{(32-W0){1'b0}}, cnt0}, RV0);
    chk("powerup_cnt1", {{(32-W1){1'b0}}, cnt1}, RV1);

    // Down count from power-up, no reset: ends at 2 after 30 edges.
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, "down");
    chk("down30_abs", {{(32-W0){1'b0}}, cnt0}, 2);

    // Reset held two cycles with either direction, then count up 1,2,3.
    step(1'b1, 1'b1, "rst_a");
    step(1'b1, 1'b0, "rst_b");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "post_rst");
    chk("post_rst_abs", {{(32-W0){1'b0}}, cnt0}, 3);

    // Up to 14, then wrap 15 -> 0 -> 1.
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, "to14");
    chk("at14_abs", {{(32-W0){1'b0}}, cnt0}, 14);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "upwrap");
    chk("upwrap_abs", {{(32-W0){1'b0}}, cnt0}, 1);

    // Direction change at 5: next values 4 then 3.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, "to5");
    step(1'b0, 1'b0, "dir_a");
    step(1'b0, 1'b0, "dir_b");
    chk("dir_abs", {{(32-W0){1'b0}}, cnt0}, 3);

    // Reset mid-count at 9, then down to 15.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, "to9");
    step(1'b1, 1'b0, "midrst");
    step(1'b0, 1'b0, "after_midrst");
    chk("midrst_abs", {{(32-W0){1'b0}}, cnt0}, 15);

    // Random mix, occasional resets.
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), "rand");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
